life_engine: RTL and testbench
==============================

Name: life_engine

Overview:
Parametrised Conway Game of Life engine with a ROWS x COLS cell grid held in registers, applying rule B3/S23 to all cells in parallel.
- Adds controlled evolution:
  - load handshake
  - single-step and free-run modes with a programmable generation period
  - toroidal or dead-border edges
  - generation counter
  - stable and extinct detection
- Sits between the pattern source (switches or pattern ROM) and the display scanner.

Parameters:
ROWS, 10, grid rows (>=3)
COLS, 10, grid columns (>=3)
WRAP, 1, 1 = toroidal edges; 0 = cells outside the grid count as dead
GEN_W, 16, generation counter width
STOP_STABLE, 1, 1 = free-run halts automatically when a generation produces no change

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
load_valid  in  1  load request
load_ready  out  1  engine accepts load (IDLE only)
load_data  in  ROWS x COLS  packed [ROWS-1:0][COLS-1:0] initial grid
run  in  1  level: free-run while high
step  in  1  single-generation request, sampled in IDLE
period  in  16  free-run: one generation every period+1 cycles
grid  out  ROWS x COLS  current registered grid
gen_count  out  GEN_W  generations since last load/reset, wraps modulo 2^GEN_W
gen_valid  out  1  one-cycle pulse, high in the cycle after each commit
stable  out  1  last commit left the grid unchanged
extinct  out  1  grid all zero (combinational from grid)
halted  out  1  FSM in HALT

Behaviour:
- Reset (async):
  - grid=0, gen_count=0, gen_valid=0, stable=0, divider=0, FSM=IDLE.
  - Hence extinct=1, load_ready=1, halted=0.
- Next-state function:
  - Per cell, a 4-bit count of 8 neighbours.
  - next = (count==3) | (count==2 & cell).
  - Neighbour index: modulo ROWS/COLS when WRAP=1; treated as 0 when WRAP=0.
- Commit (one clock edge):
  - grid<=next; gen_count<=gen_count+1; stable<=(next==grid); gen_valid<=1.
  - On every non-commit edge, gen_valid<=0.
- FSM states: IDLE, RUN, HALT.
- IDLE:
  - load_ready=1.
  - Priority: load > run > step.
  - load_valid: grid<=load_data, gen_count<=0, stable<=0; stay IDLE.
  - run=1: go to RUN; divider<=period; no commit this edge.
  - step=1 (run=0): commit on this edge; stay IDLE. step held high commits every cycle.
- RUN:
  - load_ready=0; load_valid and step are ignored.
  - run=0: go to IDLE; no commit on that edge, even if divider==0.
  - divider==0: commit; divider<=period. Otherwise divider decrements.
  - period=0 commits every cycle.
  - STOP_STABLE=1 and the committing update is stable (next==grid): go to HALT on the same edge.
- HALT:
  - No commits; load_ready=0.
  - run=0: go to IDLE.
  - period changes have no effect.
- period is sampled only at reload; a mid-run change takes effect after the current interval.
- An empty grid commit gives stable=1 and extinct=1.
- gen_count wraps from 2^GEN_W-1 to 0 without any flag.
- Reset mid-RUN or mid-HALT aborts immediately to the reset values; there is no partial commit.

Decomposition:
- Package life_pkg holds:
  - the FSM state enum (IDLE, RUN, HALT)
  - the neighbour-count width constant (4)
  - the period width constant (16)
- Sub-module life_cell: neighbour count plus rule for one cell, with WRAP handled by index generation in the parent. Instantiated ROWS*COLS times in a generate loop.
- The FSM, divider, counter and stable compare live in life_engine.

Test Plan:
1. ROWS=COLS=8, WRAP=0: load vertical blinker at (2,3),(3,3),(4,3), pulse step -> horizontal (3,2),(3,3),(3,4); gen_count=1; gen_valid high exactly one cycle; stable=0; a second step restores the vertical blinker with gen_count=2.
2. STOP_STABLE=1: load 2x2 block, run=1, period=0 -> one commit, stable=1, halted=1, gen_count=1, load_ready=0; drop run -> IDLE, load_ready=1.
3. ROWS=COLS=6, WRAP=1: load glider, run with period=0 for exactly 24 commits -> grid equals the loaded pattern; gen_count=24; stable=0 throughout.
4. WRAP=0: load a single live cell, step -> grid=0, extinct=1, stable=0; step again -> stable=1, gen_count=2.
5. period=3, run=1 for 20 cycles -> gen_valid pulses spaced exactly 4 cycles apart, first pulse 5 cycles after run is sampled; load_valid asserted during RUN leaves the grid unaffected.
6. Assert reset mid-RUN at gen_count=7 -> grid=0, gen_count=0, extinct=1, load_ready=1 immediately (async); after reset release the engine stays in IDLE with no commit until run or step.

Source files
------------

// File: rtl/life_pkg.sv
// life_pkg: shared FSM state type and widths for the Game of Life engine
package life_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;
    localparam int NBR_W = 4;
    localparam int PERIOD_W = 16;
endpackage

// File: rtl/life_cell.sv
// life_cell: counts the eight neighbours of one cell and applies rule B3/S23
module life_cell
    import life_pkg::*;
(
    input  logic       cell_i,
    input  logic [7:0] nbr_i,
    output logic       next_o
);
    logic [NBR_W-1:0] count;
    always_comb begin
        count = '0;
        for (int k = 0; k < 8; k++) count = count + NBR_W'(nbr_i[k]);
        next_o = (count == NBR_W'(3)) | ((count == NBR_W'(2)) & cell_i);
    end
endmodule

// File: rtl/life_engine.sv
// life_engine: ROWS x COLS Game of Life grid with load, single-step, timed free-run and stable halt
module life_engine
    import life_pkg::*;
#(
    parameter int ROWS        = 10,
    parameter int COLS        = 10,
    parameter bit WRAP        = 1'b1,
    parameter int GEN_W       = 16,
    parameter bit STOP_STABLE = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      load_valid_i,
    output logic                      load_ready_o,
    input  logic [ROWS-1:0][COLS-1:0] load_data_i,
    input  logic                      run_i,
    input  logic                      step_i,
    input  logic [PERIOD_W-1:0]       period_i,
    output logic [ROWS-1:0][COLS-1:0] grid_o,
    output logic [GEN_W-1:0]          gen_count_o,
    output logic                      gen_valid_o,
    output logic                      stable_o,
    output logic                      extinct_o,
    output logic                      halted_o
);
    state_e                    state_q, state_d;
    logic [PERIOD_W-1:0]       div_q, div_d;
    logic [ROWS-1:0][COLS-1:0] grid_q, grid_d, life_next;
    logic [GEN_W-1:0]          gen_count_q, gen_count_d;
    logic                      stable_q, stable_d, gen_valid_q;
    logic                      commit, load, unchanged;

    // Neighbour k walks the 3x3 window row-major; edge handling is resolved at elaboration.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [7:0] nbr;
            for (genvar k = 0; k < 9; k++) begin : g_nbr
                if (k != 4) begin : g_n
                    localparam int RR = r + k / 3 - 1;
                    localparam int CC = c + k % 3 - 1;
                    localparam int RW = (RR + ROWS) % ROWS;
                    localparam int CW = (CC + COLS) % COLS;
                    localparam bit IN = RR >= 0 && RR < ROWS && CC >= 0 && CC < COLS;
                    assign nbr[k < 4 ? k : k - 1] = (WRAP || IN) ? grid_q[RW][CW] : 1'b0;
                end
            end
            life_cell u_cell (
                .cell_i (grid_q[r][c]),
                .nbr_i  (nbr),
                .next_o (life_next[r][c])
            );
        end
    end

    assign unchanged = life_next == grid_q;

    always_comb begin
        state_d = state_q;
        div_d = div_q;
        commit = 1'b0;
        load = 1'b0;
        case (state_q)
            IDLE: begin
                load = load_valid_i;
                commit = !load_valid_i && !run_i && step_i;
                if (!load_valid_i && run_i) begin
                    state_d = RUN;
                    div_d = period_i;
                end
            end
            RUN: begin
                if (!run_i) state_d = IDLE;
                else if (div_q == '0) begin
                    commit = 1'b1;
                    div_d = period_i;
                    if (STOP_STABLE && unchanged) state_d = HALT;
                end else div_d = div_q - PERIOD_W'(1);
            end
            HALT: state_d = run_i ? HALT : IDLE;
            default: state_d = IDLE;
        endcase
        grid_d = load ? load_data_i : commit ? life_next : grid_q;
        gen_count_d = load ? '0 : gen_count_q + GEN_W'(commit);
        stable_d = load ? 1'b0 : commit ? unchanged : stable_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            div_q <= '0;
            grid_q <= '0;
            gen_count_q <= '0;
            stable_q <= 1'b0;
            gen_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q <= div_d;
            grid_q <= grid_d;
            gen_count_q <= gen_count_d;
            stable_q <= stable_d;
            gen_valid_q <= commit;
        end
    end

    assign grid_o = grid_q;
    assign gen_count_o = gen_count_q;
    assign gen_valid_o = gen_valid_q;
    assign stable_o = stable_q;
    assign extinct_o = ~|grid_q;
    assign halted_o = state_q == HALT;
    assign load_ready_o = state_q == IDLE;
endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: drives an 8x8 dead-border engine and a 6x6 toroidal engine against a cell-level model
module tb_life_engine;
    logic             clk = 1'b0;
    logic             reset_i = 1'b0;
    logic             load_valid = 1'b0;
    logic             run = 1'b0;
    logic             step = 1'b0;
    logic [15:0]      period = '0;
    logic [7:0][7:0]  ld0 = '0, g0;
    logic [5:0][5:0]  ld1 = '0, g1;
    logic [15:0]      gc0;
    logic [3:0]       gc1;
    logic             gv0, gv1, st0, st1, ex0, ex1, h0, h1, rdy0, rdy1;
    logic [63:0]      ga[2];
    logic [15:0]      gca[2];
    logic [4:0]       fa[2];
    int               vecs = 0, errs = 0;

    // Model: plain per-cell arrays; state 0=idle, 1=run, 2=halt
    int R[2]  = '{8, 6};
    int C[2]  = '{8, 6};
    int W[2]  = '{0, 1};
    int GW[2] = '{16, 4};
    bit g[2][8][8];
    int gc[2], stt[2], dv[2];
    bit gv[2], st[2];

    life_engine #(.ROWS(8), .COLS(8), .WRAP(1'b0), .GEN_W(16), .STOP_STABLE(1'b1)) dut0 (
        .clk_i(clk), .reset_i(reset_i), .load_valid_i(load_valid), .load_ready_o(rdy0),
        .load_data_i(ld0), .run_i(run), .step_i(step), .period_i(period), .grid_o(g0),
        .gen_count_o(gc0), .gen_valid_o(gv0), .stable_o(st0), .extinct_o(ex0), .halted_o(h0)
    );
    life_engine #(.ROWS(6), .COLS(6), .WRAP(1'b1), .GEN_W(4), .STOP_STABLE(1'b1)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .load_valid_i(load_valid), .load_ready_o(rdy1),
        .load_data_i(ld1), .run_i(run), .step_i(step), .period_i(period), .grid_o(g1),
        .gen_count_o(gc1), .gen_valid_o(gv1), .stable_o(st1), .extinct_o(ex1), .halted_o(h1)
    );

    assign ga[0] = g0;
    assign ga[1] = {28'b0, g1};
    assign gca[0] = gc0;
    assign gca[1] = {12'b0, gc1};
    assign fa[0] = {gv0, st0, ex0, h0, rdy0};
    assign fa[1] = {gv1, st1, ex1, h1, rdy1};

    initial forever #5 clk = ~clk;

    function automatic int nb(int d, int r, int c);
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (dr != 0 || dc != 0) begin
                    int rr = r + dr;
                    int cc = c + dc;
                    if (W[d] != 0) n += int'(g[d][(rr + R[d]) % R[d]][(cc + C[d]) % C[d]]);
                    else if (rr >= 0 && rr < R[d] && cc >= 0 && cc < C[d]) n += int'(g[d][rr][cc]);
                end
        return n;
    endfunction

    function automatic logic [63:0] mpack(int d);
        logic [63:0] v = '0;
        for (int r = 0; r < R[d]; r++)
            for (int c = 0; c < C[d]; c++) v[r * C[d] + c] = g[d][r][c];
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) g[d][r][c] = 1'b0;
            gc[d] = 0; stt[d] = 0; dv[d] = 0; gv[d] = 0; st[d] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven, then step the DUTs.
    task automatic tick();
        bit nx[8][8];
        bit same, com;
        int n;
        for (int d = 0; d < 2; d++) begin
            same = 1'b1;
            com = 1'b0;
            for (int r = 0; r < R[d]; r++)
                for (int c = 0; c < C[d]; c++) begin
                    n = nb(d, r, c);
                    nx[r][c] = (n == 3) || (n == 2 && g[d][r][c]);
                    if (nx[r][c] != g[d][r][c]) same = 1'b0;
                end
            case (stt[d])
                0: if (load_valid) begin
                    for (int r = 0; r < R[d]; r++)
                        for (int c = 0; c < C[d]; c++)
                            if (d == 0) g[d][r][c] = ld0[r][c];
                            else g[d][r][c] = ld1[r][c];
                    gc[d] = 0;
                    st[d] = 1'b0;
                end else if (run) begin
                    stt[d] = 1;
                    dv[d] = int'(period);
                end else if (step) com = 1'b1;
                1: if (!run) stt[d] = 0;
                   else if (dv[d] == 0) begin
                       com = 1'b1;
                       dv[d] = int'(period);
                       if (same) stt[d] = 2;
                   end else dv[d] = dv[d] - 1;
                default: if (!run) stt[d] = 0;
            endcase
            if (com) begin
                for (int r = 0; r < R[d]; r++)
                    for (int c = 0; c < C[d]; c++) g[d][r][c] = nx[r][c];
                gc[d] = (gc[d] + 1) % (1 << GW[d]);
                st[d] = same;
            end
            gv[d] = com;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_both(input logic [7:0][7:0] a, input logic [5:0][5:0] b);
        ld0 = a;
        ld1 = b;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_i = 1'b1;
        #1;
        model_reset();
        vecs++; if (ga[0] !== 64'd0 || gc0 !== 16'd0) begin errs++; $display("FAIL reset0 grid=%h gen=%0d exp 0/0", ga[0], gc0); end
        vecs++; if (fa[0] !== 5'b00101) begin errs++; $display("FAIL reset0_flags got=%b exp=00101", fa[0]); end
        vecs++; if (ga[1] !== 64'd0 || fa[1] !== 5'b00101) begin errs++; $display("FAIL reset1 grid=%h flags=%b exp 0/00101", ga[1], fa[1]); end
        @(posedge clk);
        #1 reset_i = 1'b0;
    endtask

    task automatic test_blinker();
        logic [7:0][7:0] vert, horz;
        vert = '0; vert[2][3] = 1'b1; vert[3][3] = 1'b1; vert[4][3] = 1'b1;
        horz = '0; horz[3][2] = 1'b1; horz[3][3] = 1'b1; horz[3][4] = 1'b1;
        load_both(vert, 36'({$urandom(), $urandom()}));
        step = 1'b1;
        tick();
        step = 1'b0;
        vecs++; if (g0 !== horz) begin errs++; $display("FAIL blinker_h got=%h exp=%h", g0, horz); end
        vecs++; if (gc0 !== 16'd1 || {gv0, st0} !== 2'b10) begin errs++; $display("FAIL blinker_h_status gen=%0d gv/st=%b exp 1/10", gc0, {gv0, st0}); end
        tick();
        vecs++; if (gv0 !== 1'b0) begin errs++; $display("FAIL blinker_pulse gen_valid=%b exp=0", gv0); end
        step = 1'b1;
        tick();
        step = 1'b0;
        vecs++; if (g0 !== vert || gc0 !== 16'd2) begin errs++; $display("FAIL blinker_v got=%h gen=%0d exp=%h gen=2", g0, gc0, vert); end
    endtask

    task automatic test_block();
        logic [7:0][7:0] b0;
        logic [5:0][5:0] b1;
        b0 = '0; b0[1][1] = 1'b1; b0[1][2] = 1'b1; b0[2][1] = 1'b1; b0[2][2] = 1'b1;
        b1 = '0; b1[1][1] = 1'b1; b1[1][2] = 1'b1; b1[2][1] = 1'b1; b1[2][2] = 1'b1;
        load_both(b0, b1);
        period = 16'd0;
        run = 1'b1;
        tick();
        vecs++; if (gv0 !== 1'b0 || gc0 !== 16'd0 || rdy0 !== 1'b0) begin errs++; $display("FAIL block_enter gv=%b gen=%0d ready=%b exp 0/0/0", gv0, gc0, rdy0); end
        tick();
        vecs++; if ({gv0, st0, h0, rdy0} !== 4'b1110 || gc0 !== 16'd1) begin errs++; $display("FAIL block_halt gv/st/h/rdy=%b gen=%0d exp 1110/1", {gv0, st0, h0, rdy0}, gc0); end
        vecs++; if ({st1, h1} !== 2'b11 || gc1 !== 4'd1) begin errs++; $display("FAIL block_halt1 st/h=%b gen=%0d exp 11/1", {st1, h1}, gc1); end
        period = 16'd5;
        for (int i = 0; i < 3; i++) tick();
        vecs++; if (gc0 !== 16'd1 || gv0 !== 1'b0 || h0 !== 1'b1) begin errs++; $display("FAIL block_hold gen=%0d gv=%b h=%b exp 1/0/1", gc0, gv0, h0); end
        run = 1'b0;
        tick();
        vecs++; if ({h0, rdy0, h1, rdy1} !== 4'b0101) begin errs++; $display("FAIL block_idle h/rdy=%b exp=0101", {h0, rdy0, h1, rdy1}); end
    endtask

    task automatic test_glider();
        logic [7:0][7:0] vert;
        logic [5:0][5:0] gl;
        vert = '0; vert[2][3] = 1'b1; vert[3][3] = 1'b1; vert[4][3] = 1'b1;
        gl = '0; gl[0][1] = 1'b1; gl[1][2] = 1'b1; gl[2][0] = 1'b1; gl[2][1] = 1'b1; gl[2][2] = 1'b1;
        load_both(vert, gl);
        period = 16'd0;
        run = 1'b1;
        tick();
        for (int i = 0; i < 24; i++) begin
            tick();
            vecs++; if ({gv1, st1, h1} !== 3'b100) begin errs++; $display("FAIL glider_gen%0d gv/st/h=%b exp=100", i + 1, {gv1, st1, h1}); end
        end
        run = 1'b0;
        tick();
        vecs++; if (g1 !== gl || gc1 !== 4'd8) begin errs++; $display("FAIL glider_wrap got=%h gen=%0d exp=%h gen=8", g1, gc1, gl); end
    endtask

    task automatic test_single();
        logic [7:0][7:0] s;
        s = '0; s[4][4] = 1'b1;
        load_both(s, 36'({$urandom(), $urandom()}));
        step = 1'b1;
        tick();
        vecs++; if (g0 !== 64'd0 || {ex0, st0} !== 2'b10) begin errs++; $display("FAIL single_die grid=%h ex/st=%b exp 0/10", g0, {ex0, st0}); end
        tick();
        step = 1'b0;
        vecs++; if (st0 !== 1'b1 || ex0 !== 1'b1 || gc0 !== 16'd2) begin errs++; $display("FAIL single_empty st=%b ex=%b gen=%0d exp 1/1/2", st0, ex0, gc0); end
    endtask

    task automatic test_period();
        logic [7:0][7:0] vert;
        logic [5:0][5:0] gl;
        bit exp_gv;
        vert = '0; vert[2][3] = 1'b1; vert[3][3] = 1'b1; vert[4][3] = 1'b1;
        gl = '0; gl[0][1] = 1'b1; gl[1][2] = 1'b1; gl[2][0] = 1'b1; gl[2][1] = 1'b1; gl[2][2] = 1'b1;
        load_both(vert, gl);
        period = 16'd3;
        run = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            load_valid = i >= 8 && i <= 10;
            if (load_valid) ld0 = {$urandom(), $urandom()};
            tick();
            exp_gv = i >= 5 && (i - 5) % 4 == 0;
            vecs++; if (gv0 !== exp_gv || gv1 !== exp_gv) begin errs++; $display("FAIL period_pulse cyc%0d gv0=%b gv1=%b exp=%b", i, gv0, gv1, exp_gv); end
            vecs++; if (ga[0] !== mpack(0)) begin errs++; $display("FAIL period_grid cyc%0d got=%h exp=%h", i, ga[0], mpack(0)); end
        end
        load_valid = 1'b0;
        run = 1'b0;
        tick();
    endtask

    task automatic test_reset_midrun();
        logic [7:0][7:0] vert;
        vert = '0; vert[2][3] = 1'b1; vert[3][3] = 1'b1; vert[4][3] = 1'b1;
        load_both(vert, 36'({$urandom(), $urandom()}));
        period = 16'd0;
        run = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        vecs++; if (gc0 !== 16'd7) begin errs++; $display("FAIL midrun_count gen=%0d exp=7", gc0); end
        #2 reset_i = 1'b1;
        #1;
        model_reset();
        vecs++; if (g0 !== 64'd0 || gc0 !== 16'd0 || {ex0, rdy0, gv0} !== 3'b110) begin errs++; $display("FAIL midrun_reset grid=%h gen=%0d ex/rdy/gv=%b exp 0/0/110", g0, gc0, {ex0, rdy0, gv0}); end
        @(posedge clk);
        #1;
        run = 1'b0;
        reset_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++; if (gv0 !== 1'b0 || gc0 !== 16'd0 || rdy0 !== 1'b1) begin errs++; $display("FAIL midrun_idle cyc%0d gv=%b gen=%0d rdy=%b exp 0/0/1", i, gv0, gc0, rdy0); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load_valid = $urandom_range(0, 11) == 0;
            if (load_valid) begin
                ld0 = {$urandom(), $urandom()};
                ld1 = 36'({$urandom(), $urandom()});
            end
            if ($urandom_range(0, 9) == 0) run = !run;
            step = $urandom_range(0, 2) == 0;
            period = 16'($urandom_range(0, 3));
            tick();
            for (int d = 0; d < 2; d++) begin
                vecs++; if (ga[d] !== mpack(d)) begin errs++; $display("FAIL rand_grid%0d cyc%0d got=%h exp=%h", d, i, ga[d], mpack(d)); end
                vecs++; if (gca[d] !== 16'(gc[d])) begin errs++; $display("FAIL rand_gen%0d cyc%0d got=%0d exp=%0d", d, i, gca[d], gc[d]); end
                vecs++; if (fa[d] !== {gv[d], st[d], mpack(d) == 64'd0, stt[d] == 2, stt[d] == 0}) begin
                    errs++;
                    $display("FAIL rand_flags%0d cyc%0d gv/st/ex/h/rdy got=%b exp=%b", d, i, fa[d], {gv[d], st[d], mpack(d) == 64'd0, stt[d] == 2, stt[d] == 0});
                end
            end
        end
        run = 1'b0;
        step = 1'b0;
        load_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_block();
        test_glider();
        test_single();
        test_period();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
